// File: rtl/tcp_bus_if.sv
// tcpBus command/data/response bundle shared by requesters and the AXI4 bridge port.
// The master modport issues commands and write beats; the slave modport answers them.
interface tcp_bus_if #(
  parameter int unsigned DATA_W = 128
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [31:0]       cmd_addr;
  logic [31:0]       cmd_size;
  logic              wdata_valid;
  logic              wdata_ready;
  logic              wdata_last;
  logic [DATA_W-1:0] wdata_fragment;
  logic              rdata_valid;
  logic              rdata_ready;
  logic              rdata_last;
  logic [DATA_W-1:0] rdata_fragment;
  logic              rsp_valid;
  logic [1:0]        rsp_payload;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_size,
    output wdata_valid, wdata_last, wdata_fragment, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata_last, rdata_fragment,
    input  rsp_valid, rsp_payload
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size,
    input  wdata_valid, wdata_last, wdata_fragment, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata_last, rdata_fragment,
    output rsp_valid, rsp_payload
  );
endinterface

// File: rtl/tcp_bus_arbiter.sv
// Two-port round-robin arbiter sharing one tcpBus port, granting whole transactions,
// forcing the burst length from the byte size and flagging protocol violations.
module tcp_bus_arbiter #(
  parameter int unsigned DATA_BYTES = 16,
  parameter int unsigned DATA_W     = 8 * DATA_BYTES
) (
  input  logic       clk,
  input  logic       rst_n,
  tcp_bus_if.slave   s0,
  tcp_bus_if.slave   s1,
  tcp_bus_if.master  m,
  output logic [1:0] o_grant,
  output logic       o_protocol_error
);
  localparam int unsigned LOG2_BYTES = $clog2(DATA_BYTES);
  localparam int unsigned CNT_W      = 33;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_grant, w_grant_nxt;
  logic               r_last_s1, w_last_s1_nxt;
  logic [CNT_W-1:0]   r_beats_left, w_beats_nxt;
  logic               r_rsp_seen, w_rsp_seen_nxt;
  logic               r_perr, w_perr_nxt;
  logic               r_write, w_write_nxt;
  logic               w_data_done;

  logic               w_pick_s1;
  logic [31:0]        w_pick_size;
  logic [CNT_W-1:0]   w_beats_raw, w_pick_beats;
  logic               w_last_beat;

  logic               w_own_s1;
  logic               w_own_cmd_valid, w_own_cmd_write;
  logic [31:0]        w_own_cmd_addr, w_own_cmd_size;
  logic               w_own_wdata_valid, w_own_wdata_last, w_own_rdata_ready;
  logic [DATA_W-1:0]  w_own_wdata_fragment;

  logic               w_to_cmd_ready, w_to_wdata_ready, w_to_rdata_valid;
  logic               w_to_rdata_last, w_to_rsp_valid;
  logic [DATA_W-1:0]  w_to_rdata_fragment;
  logic [1:0]         w_to_rsp_payload;

  // Tie goes to the port that was not granted last.
  assign w_pick_s1    = s1.cmd_valid && (!s0.cmd_valid || !r_last_s1);
  assign w_pick_size  = w_pick_s1 ? s1.cmd_size : s0.cmd_size;
  assign w_beats_raw  = ({1'b0, w_pick_size} + CNT_W'(DATA_BYTES - 1)) >> LOG2_BYTES;
  assign w_pick_beats = (w_pick_size == 32'd0) ? CNT_W'(1) : w_beats_raw;
  assign w_last_beat  = (r_beats_left == CNT_W'(1));

  assign w_own_s1             = r_grant[1];
  assign w_own_cmd_valid      = w_own_s1 ? s1.cmd_valid      : s0.cmd_valid;
  assign w_own_cmd_write      = w_own_s1 ? s1.cmd_write      : s0.cmd_write;
  assign w_own_cmd_addr       = w_own_s1 ? s1.cmd_addr       : s0.cmd_addr;
  assign w_own_cmd_size       = w_own_s1 ? s1.cmd_size       : s0.cmd_size;
  assign w_own_wdata_valid    = w_own_s1 ? s1.wdata_valid    : s0.wdata_valid;
  assign w_own_wdata_last     = w_own_s1 ? s1.wdata_last     : s0.wdata_last;
  assign w_own_wdata_fragment = w_own_s1 ? s1.wdata_fragment : s0.wdata_fragment;
  assign w_own_rdata_ready    = w_own_s1 ? s1.rdata_ready    : s0.rdata_ready;

  // Owner-bound signals fan out to the granted port only; the other port sees zeros.
  assign s0.cmd_ready      = r_grant[0] & w_to_cmd_ready;
  assign s0.wdata_ready    = r_grant[0] & w_to_wdata_ready;
  assign s0.rdata_valid    = r_grant[0] & w_to_rdata_valid;
  assign s0.rdata_last     = r_grant[0] & w_to_rdata_last;
  assign s0.rdata_fragment = r_grant[0] ? w_to_rdata_fragment : {DATA_W{1'b0}};
  assign s0.rsp_valid      = r_grant[0] & w_to_rsp_valid;
  assign s0.rsp_payload    = r_grant[0] ? w_to_rsp_payload : 2'b00;
  assign s1.cmd_ready      = r_grant[1] & w_to_cmd_ready;
  assign s1.wdata_ready    = r_grant[1] & w_to_wdata_ready;
  assign s1.rdata_valid    = r_grant[1] & w_to_rdata_valid;
  assign s1.rdata_last     = r_grant[1] & w_to_rdata_last;
  assign s1.rdata_fragment = r_grant[1] ? w_to_rdata_fragment : {DATA_W{1'b0}};
  assign s1.rsp_valid      = r_grant[1] & w_to_rsp_valid;
  assign s1.rsp_payload    = r_grant[1] ? w_to_rsp_payload : 2'b00;

  assign o_grant          = r_grant;
  assign o_protocol_error = r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 2'b00;
      r_last_s1    <= 1'b1;
      r_beats_left <= '0;
      r_rsp_seen   <= 1'b0;
      r_perr       <= 1'b0;
      r_write      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_s1    <= w_last_s1_nxt;
      r_beats_left <= w_beats_nxt;
      r_rsp_seen   <= w_rsp_seen_nxt;
      r_perr       <= w_perr_nxt;
      r_write      <= w_write_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_grant_nxt         = r_grant;
    w_last_s1_nxt       = r_last_s1;
    w_beats_nxt         = r_beats_left;
    w_rsp_seen_nxt      = r_rsp_seen;
    w_perr_nxt          = r_perr;
    w_write_nxt         = r_write;
    w_data_done         = 1'b0;
    w_to_cmd_ready      = 1'b0;
    w_to_wdata_ready    = 1'b0;
    w_to_rdata_valid    = 1'b0;
    w_to_rdata_last     = 1'b0;
    w_to_rdata_fragment = {DATA_W{1'b0}};
    w_to_rsp_valid      = 1'b0;
    w_to_rsp_payload    = 2'b00;
    m.cmd_valid         = 1'b0;
    m.cmd_write         = 1'b0;
    m.cmd_addr          = 32'd0;
    m.cmd_size          = 32'd0;
    m.wdata_valid       = 1'b0;
    m.wdata_last        = 1'b0;
    m.wdata_fragment    = {DATA_W{1'b0}};
    m.rdata_ready       = 1'b0;

    // Only the first response of an active transaction reaches the owner.
    if (m.rsp_valid) begin
      if (r_state == S_IDLE || r_rsp_seen) begin
        w_perr_nxt = 1'b1;
      end else begin
        w_to_rsp_valid   = 1'b1;
        w_to_rsp_payload = m.rsp_payload;
        w_rsp_seen_nxt   = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (s0.cmd_valid || s1.cmd_valid) begin
          w_grant_nxt = w_pick_s1 ? 2'b10 : 2'b01;
          w_beats_nxt = w_pick_beats;
          w_write_nxt = w_pick_s1 ? s1.cmd_write : s0.cmd_write;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        m.cmd_valid    = w_own_cmd_valid;
        m.cmd_write    = w_own_cmd_write;
        m.cmd_addr     = w_own_cmd_addr;
        m.cmd_size     = w_own_cmd_size;
        w_to_cmd_ready = m.cmd_ready;
        if (w_own_cmd_valid && m.cmd_ready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (r_write) begin
          m.wdata_valid    = w_own_wdata_valid;
          m.wdata_last     = w_last_beat;
          m.wdata_fragment = w_own_wdata_fragment;
          w_to_wdata_ready = m.wdata_ready;
          if (w_own_wdata_valid && m.wdata_ready) begin
            w_beats_nxt = r_beats_left - CNT_W'(1);
            if (w_own_wdata_last != w_last_beat) w_perr_nxt = 1'b1;
            w_data_done = w_last_beat;
          end
        end else begin
          m.rdata_ready       = w_own_rdata_ready;
          w_to_rdata_valid    = m.rdata_valid;
          w_to_rdata_last     = m.rdata_last;
          w_to_rdata_fragment = m.rdata_fragment;
          if (m.rdata_valid && w_own_rdata_ready) begin
            if (r_beats_left != '0) w_beats_nxt = r_beats_left - CNT_W'(1);
            if (m.rdata_last) begin
              if (!w_last_beat) w_perr_nxt = 1'b1;
              w_data_done = 1'b1;
            end
          end
        end
        if (w_data_done) w_state_nxt = w_rsp_seen_nxt ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (w_rsp_seen_nxt) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (r_state != S_IDLE && w_state_nxt == S_IDLE) begin
      w_grant_nxt    = 2'b00;
      w_last_s1_nxt  = r_grant[1];
      w_rsp_seen_nxt = 1'b0;
    end
  end
endmodule

// File: tb/tb_tcp_bus_arbiter.sv
// Directed bench for tcp_bus_arbiter: arbitration order, burst length forcing,
// response routing, protocol-error detection and asynchronous reset.
module tb_tcp_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       perr;
  int         n_checks = 0;
  int         n_errors = 0;

  tcp_bus_if #(.DATA_W(128)) s0_if ();
  tcp_bus_if #(.DATA_W(128)) s1_if ();
  tcp_bus_if #(.DATA_W(128)) m_if ();

  tcp_bus_arbiter #(.DATA_BYTES(16), .DATA_W(128)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s0               (s0_if),
    .s1               (s1_if),
    .m                (m_if),
    .o_grant          (grant),
    .o_protocol_error (perr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.cmd_valid = 0; s0_if.cmd_write = 0; s0_if.cmd_addr = 0; s0_if.cmd_size = 0;
    s0_if.wdata_valid = 0; s0_if.wdata_last = 0; s0_if.wdata_fragment = 0; s0_if.rdata_ready = 0;
    s1_if.cmd_valid = 0; s1_if.cmd_write = 0; s1_if.cmd_addr = 0; s1_if.cmd_size = 0;
    s1_if.wdata_valid = 0; s1_if.wdata_last = 0; s1_if.wdata_fragment = 0; s1_if.rdata_ready = 0;
    m_if.cmd_ready = 0; m_if.wdata_ready = 0; m_if.rdata_valid = 0; m_if.rdata_last = 0;
    m_if.rdata_fragment = 0; m_if.rsp_valid = 0; m_if.rsp_payload = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL reset_grant: got %0h want 0", grant); end
    n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL reset_perr: got %0b want 0", perr); end
    n_checks++; if (m_if.cmd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_cmd_valid: got %0b want 0", m_if.cmd_valid); end
    n_checks++; if (s0_if.cmd_ready !== 1'b0) begin n_errors++; $display("FAIL reset_s0_cmd_ready: got %0b want 0", s0_if.cmd_ready); end
  endtask

  task automatic test_single_write();
    logic [127:0] frag;
    s0_if.cmd_valid = 1; s0_if.cmd_write = 1; s0_if.cmd_addr = 32'h1000; s0_if.cmd_size = 32'd48;
    m_if.cmd_ready = 1; m_if.wdata_ready = 1;
    n_checks++; if (m_if.cmd_valid !== 1'b0) begin n_errors++; $display("FAIL wr_idle_m_cmd_valid: got %0b want 0", m_if.cmd_valid); end
    tick();
    n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL wr_grant: got %0h want 1", grant); end
    n_checks++; if (m_if.cmd_addr !== 32'h1000) begin n_errors++; $display("FAIL wr_m_cmd_addr: got %0h want 1000", m_if.cmd_addr); end
    n_checks++; if (s0_if.cmd_ready !== 1'b1) begin n_errors++; $display("FAIL wr_s0_cmd_ready: got %0b want 1", s0_if.cmd_ready); end
    n_checks++; if (s1_if.cmd_ready !== 1'b0) begin n_errors++; $display("FAIL wr_s1_cmd_ready: got %0b want 0", s1_if.cmd_ready); end
    tick();
    s0_if.cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      frag = {4{32'hA500_0000 + 32'(i)}};
      s0_if.wdata_valid = 1; s0_if.wdata_last = (i == 2); s0_if.wdata_fragment = frag;
      #1;
      n_checks++; if (m_if.wdata_last !== (i == 2)) begin n_errors++; $display("FAIL wr_m_wdata_last beat %0d: got %0b want %0b", i, m_if.wdata_last, (i == 2)); end
      n_checks++; if (m_if.wdata_fragment !== frag) begin n_errors++; $display("FAIL wr_m_wdata_fragment beat %0d: got %0h want %0h", i, m_if.wdata_fragment, frag); end
      tick();
    end
    s0_if.wdata_valid = 0; s0_if.wdata_last = 0;
    m_if.rsp_valid = 1; m_if.rsp_payload = 2'b00;
    #1;
    n_checks++; if (s0_if.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL wr_s0_rsp_valid: got %0b want 1", s0_if.rsp_valid); end
    n_checks++; if (s1_if.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL wr_s1_rsp_valid: got %0b want 0", s1_if.rsp_valid); end
    n_checks++; if (s0_if.rsp_payload !== 2'b00) begin n_errors++; $display("FAIL wr_s0_rsp_payload: got %0h want 0", s0_if.rsp_payload); end
    tick();
    m_if.rsp_valid = 0;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL wr_grant_end: got %0h want 0", grant); end
    n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL wr_perr: got %0b want 0", perr); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_grant;
    do_reset();
    s0_if.cmd_valid = 1; s0_if.cmd_write = 0; s0_if.cmd_size = 32'd16; s0_if.rdata_ready = 1;
    s1_if.cmd_valid = 1; s1_if.cmd_write = 0; s1_if.cmd_size = 32'd16; s1_if.rdata_ready = 1;
    m_if.cmd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      n_checks++; if (grant !== exp_grant) begin n_errors++; $display("FAIL rr_grant txn %0d: got %0h want %0h", k, grant, exp_grant); end
      tick();
      m_if.rdata_valid = 1; m_if.rdata_last = 1; m_if.rdata_fragment = 128'(k + 7);
      m_if.rsp_valid = 1; m_if.rsp_payload = 2'b00;
      #1;
      if (exp_grant == 2'b01) begin
        n_checks++; if ({s0_if.rdata_valid, s1_if.rdata_valid} !== 2'b10) begin n_errors++; $display("FAIL rr_rdata_valid txn %0d: got %0b want 10", k, {s0_if.rdata_valid, s1_if.rdata_valid}); end
        n_checks++; if (s0_if.rdata_fragment !== 128'(k + 7)) begin n_errors++; $display("FAIL rr_rdata_fragment txn %0d: got %0h want %0h", k, s0_if.rdata_fragment, k + 7); end
      end else begin
        n_checks++; if ({s0_if.rdata_valid, s1_if.rdata_valid} !== 2'b01) begin n_errors++; $display("FAIL rr_rdata_valid txn %0d: got %0b want 01", k, {s0_if.rdata_valid, s1_if.rdata_valid}); end
        n_checks++; if (s0_if.rdata_fragment !== 128'd0) begin n_errors++; $display("FAIL rr_nonowner_fragment txn %0d: got %0h want 0", k, s0_if.rdata_fragment); end
      end
      tick();
      m_if.rdata_valid = 0; m_if.rdata_last = 0; m_if.rsp_valid = 0;
      n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rr_idle txn %0d: got %0h want 0", k, grant); end
    end
    clear_inputs();
    n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL rr_perr: got %0b want 0", perr); end
  endtask

  task automatic test_beat_rounding();
    logic [31:0] sizes [3];
    logic [32:0] beats [3];
    sizes[0] = 32'd0;          beats[0] = 33'd1;
    sizes[1] = 32'd17;         beats[1] = 33'd2;
    sizes[2] = 32'hFFFF_FFF1;  beats[2] = 33'h1000_0000;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      s0_if.cmd_valid = 1; s0_if.cmd_write = 1; s0_if.cmd_size = sizes[i];
      tick();
      n_checks++; if (dut.r_beats_left !== beats[i]) begin n_errors++; $display("FAIL beats size %0h: got %0h want %0h", sizes[i], dut.r_beats_left, beats[i]); end
    end
    do_reset();
  endtask

  task automatic test_early_rsp();
    s0_if.cmd_valid = 1; s0_if.cmd_write = 0; s0_if.cmd_size = 32'd32; s0_if.rdata_ready = 1;
    m_if.cmd_ready = 1;
    tick();
    tick();
    s0_if.cmd_valid = 0;
    m_if.rdata_valid = 1; m_if.rdata_last = 0; m_if.rsp_valid = 1; m_if.rsp_payload = 2'b10;
    #1;
    n_checks++; if (s0_if.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL ersp_rsp_valid: got %0b want 1", s0_if.rsp_valid); end
    n_checks++; if (s0_if.rsp_payload !== 2'b10) begin n_errors++; $display("FAIL ersp_rsp_payload: got %0h want 2", s0_if.rsp_payload); end
    n_checks++; if (m_if.rdata_ready !== 1'b1) begin n_errors++; $display("FAIL ersp_m_rdata_ready: got %0b want 1", m_if.rdata_ready); end
    tick();
    m_if.rsp_valid = 0; m_if.rdata_last = 1;
    #1;
    n_checks++; if (s0_if.rdata_last !== 1'b1) begin n_errors++; $display("FAIL ersp_rdata_last: got %0b want 1", s0_if.rdata_last); end
    n_checks++; if (s0_if.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL ersp_no_second_rsp: got %0b want 0", s0_if.rsp_valid); end
    tick();
    m_if.rdata_valid = 0; m_if.rdata_last = 0;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL ersp_idle: got %0h want 0", grant); end
    n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL ersp_perr: got %0b want 0", perr); end
    clear_inputs();
  endtask

  task automatic test_early_last();
    s1_if.cmd_valid = 1; s1_if.cmd_write = 1; s1_if.cmd_size = 32'd64;
    m_if.cmd_ready = 1; m_if.wdata_ready = 1;
    tick();
    n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL elast_grant: got %0h want 2", grant); end
    tick();
    s1_if.cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      s1_if.wdata_valid = 1; s1_if.wdata_last = (i == 1); s1_if.wdata_fragment = 128'(i);
      #1;
      n_checks++; if (m_if.wdata_last !== (i == 3)) begin n_errors++; $display("FAIL elast_m_wdata_last beat %0d: got %0b want %0b", i, m_if.wdata_last, (i == 3)); end
      n_checks++; if (perr !== (i >= 2)) begin n_errors++; $display("FAIL elast_perr beat %0d: got %0b want %0b", i, perr, (i >= 2)); end
      tick();
    end
    s1_if.wdata_valid = 0; s1_if.wdata_last = 0;
    m_if.rsp_valid = 1; m_if.rsp_payload = 2'b01;
    #1;
    n_checks++; if ({s1_if.rsp_valid, s0_if.rsp_valid} !== 2'b10) begin n_errors++; $display("FAIL elast_rsp_route: got %0b want 10", {s1_if.rsp_valid, s0_if.rsp_valid}); end
    tick();
    m_if.rsp_valid = 0;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL elast_idle: got %0h want 0", grant); end
    n_checks++; if (perr !== 1'b1) begin n_errors++; $display("FAIL elast_perr_sticky: got %0b want 1", perr); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_write();
    s0_if.cmd_valid = 1; s0_if.cmd_write = 1; s0_if.cmd_size = 32'd64;
    m_if.cmd_ready = 1; m_if.wdata_ready = 1;
    tick();
    tick();
    s0_if.cmd_valid = 0; s0_if.wdata_valid = 1;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_if.wdata_valid !== 1'b0) begin n_errors++; $display("FAIL rst_m_wdata_valid: got %0b want 0", m_if.wdata_valid); end
    n_checks++; if (s0_if.wdata_ready !== 1'b0) begin n_errors++; $display("FAIL rst_s0_wdata_ready: got %0b want 0", s0_if.wdata_ready); end
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rst_grant: got %0h want 0", grant); end
    n_checks++; if (perr !== 1'b0) begin n_errors++; $display("FAIL rst_perr: got %0b want 0", perr); end
    clear_inputs();
    #1;
    rst_n = 1'b1;
    tick();
    s0_if.cmd_valid = 1; s0_if.cmd_size = 32'd16;
    s1_if.cmd_valid = 1; s1_if.cmd_size = 32'd16;
    tick();
    n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL rst_next_grant: got %0h want 1", grant); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    test_reset();
    #12;
    rst_n = 1'b1;
    tick();
    test_single_write();
    test_round_robin();
    test_beat_rounding();
    test_early_rsp();
    test_early_last();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
